// File: rtl/screen_pkg.sv
// Shared constants, state encoding and decode helper for the screen timing pipeline.
package screen_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 834;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 456;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Half-open interval test [lo, hi) on a raster coordinate.
    function automatic logic in_range(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/screen_delay_line.sv
// Fixed-depth register pipeline with synchronous reset to a parameterised value.
module screen_delay_line #(
    parameter int unsigned   W       = 1,
    parameter int unsigned   DEPTH   = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= RST_VAL;
            end
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/screen_timing_gen.sv
// Raster timing master: prefetch coordinates one stage early, syncs/de delayed to
// line up with the downstream registered pixel value. Runs in whole frames only.
module screen_timing_gen
    import screen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] pf_pix_row,
    output logic [COORD_W-1:0] pf_pix_col,
    output logic               pf_active,
    output logic               frame_start,
    output logic               line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIX_LAT < 1) begin : g_bad_cfg
        $error("screen_timing_gen: totals must be <= 1024 and PIX_LAT >= 1");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    state_e             state_q;
    logic [COORD_W-1:0] h_q;
    logic [COORD_W-1:0] v_q;

    // Stopping is only honoured on the last cycle of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) state_q <= RUN;
                end
                RUN: begin
                    if (h_q == H_LAST) begin
                        h_q <= '0;
                        if (v_q == V_LAST) begin
                            v_q <= '0;
                            if (!en) state_q <= IDLE;
                        end else begin
                            v_q <= v_q + ONE;
                        end
                    end else begin
                        h_q <= h_q + ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic       running;
    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] dly_out;

    assign running     = (state_q == RUN);
    assign pf_active   = running && (h_q < H_VIS) && (v_q < V_VIS);
    assign hs_raw      = running && in_range(h_q, HS_START, HS_END);
    assign vs_raw      = running && in_range(v_q, VS_START, VS_END);
    assign frame_start = running && (h_q == '0) && (v_q == '0);
    assign line_start  = running && (h_q == '0);
    assign pf_pix_row  = v_q;
    assign pf_pix_col  = h_q;

    screen_delay_line #(
        .W       (3),
        .DEPTH   (PIX_LAT),
        .RST_VAL (3'b000)
    ) u_dly (
        .clk_i  (clk),
        .rst_i  (rst),
        .din_i  ({hs_raw, vs_raw, pf_active}),
        .dout_o (dly_out)
    );

    assign hsync = dly_out[2] ? H_POL : ~H_POL;
    assign vsync = dly_out[1] ? V_POL : ~V_POL;
    assign de    = dly_out[0];

endmodule

// File: tb/tb_screen_timing_gen.sv
// Scoreboard bench: two instances (positive sync/latency 1, negative sync/latency 3)
// share stimulus; expected responses are queued per cycle and checked by a monitor.
module tb_screen_timing_gen;

    localparam int H_TOT = 14;
    localparam int V_TOT = 8;
    localparam int F_LEN = H_TOT * V_TOT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;

    logic       hs_a, vs_a, de_a, act_a, fs_a, ls_a;
    logic [9:0] row_a, col_a;
    logic       hs_b, vs_b, de_b, act_b, fs_b, ls_b;
    logic [9:0] row_b, col_b;

    always #5 clk = ~clk;

    screen_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_LAT(1)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .pf_pix_row(row_a), .pf_pix_col(col_a),
        .pf_active(act_a), .frame_start(fs_a), .line_start(ls_a)
    );

    screen_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(3)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .pf_pix_row(row_b), .pf_pix_col(col_b),
        .pf_active(act_b), .frame_start(fs_b), .line_start(ls_b)
    );

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic       act, fs, ls;
        logic       hs_a, vs_a, de_a;
        logic       hs_b, vs_b, de_b;
        bit         win;
        bit         chk_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: frame position as a single cycle index plus sync pipelines.
    bit         m_run = 1'b0;
    int         m_t   = 0;
    logic [2:0] pa    = '0;
    logic [2:0] pb [3];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input bit w, input bit c);
        int         col, row;
        logic [2:0] raw;
        exp_t       x;
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        col = m_t % H_TOT;
        row = m_t / H_TOT;
        raw = {m_run && col >= 10 && col < 13, m_run && row >= 5 && row < 7,
               m_run && col < 8 && row < 4};
        if (r) begin
            m_run = 1'b0;
            m_t   = 0;
            pa    = '0;
            for (int i = 0; i < 3; i++) pb[i] = '0;
        end else begin
            pa    = raw;
            pb[2] = pb[1];
            pb[1] = pb[0];
            pb[0] = raw;
            if (!m_run) begin
                if (e) m_run = 1'b1;
            end else if (m_t == F_LEN - 1) begin
                m_t = 0;
                if (!e) m_run = 1'b0;
            end else begin
                m_t++;
            end
        end
        col       = m_t % H_TOT;
        row       = m_t / H_TOT;
        x.row     = 10'(row);
        x.col     = 10'(col);
        x.act     = m_run && col < 8 && row < 4;
        x.fs      = m_run && m_t == 0;
        x.ls      = m_run && col == 0;
        x.hs_a    = pa[2];
        x.vs_a    = pa[1];
        x.de_a    = pa[0];
        x.hs_b    = ~pb[2][2];
        x.vs_b    = ~pb[2][1];
        x.de_b    = pb[2][0];
        x.win     = w;
        x.chk_cnt = c;
        exp_q.push_back(x);
    endtask

    task automatic run_to(input int col, input int row);
        int n = 0;
        while (!(m_run && m_t == row * H_TOT + col) && n < 300) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL run_to: position (%0d,%0d) not reached", col, row);
        end
    endtask

    // Monitor: compare each queued expectation against the DUT mid-cycle.
    int c_hs_a = 0, c_vs_a = 0, c_de_a = 0, c_fs = 0, c_ls = 0;
    int c_hs_b = 0, c_vs_b = 0, c_de_b = 0;

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("row_a",  32'(row_a), 32'(x.row));
                chk("col_a",  32'(col_a), 32'(x.col));
                chk("act_a",  32'(act_a), 32'(x.act));
                chk("fs_a",   32'(fs_a),  32'(x.fs));
                chk("ls_a",   32'(ls_a),  32'(x.ls));
                chk("hsync_a", 32'(hs_a), 32'(x.hs_a));
                chk("vsync_a", 32'(vs_a), 32'(x.vs_a));
                chk("de_a",   32'(de_a),  32'(x.de_a));
                chk("row_b",  32'(row_b), 32'(x.row));
                chk("col_b",  32'(col_b), 32'(x.col));
                chk("act_b",  32'(act_b), 32'(x.act));
                chk("fs_b",   32'(fs_b),  32'(x.fs));
                chk("ls_b",   32'(ls_b),  32'(x.ls));
                chk("hsync_b", 32'(hs_b), 32'(x.hs_b));
                chk("vsync_b", 32'(vs_b), 32'(x.vs_b));
                chk("de_b",   32'(de_b),  32'(x.de_b));
                if (x.win) begin
                    c_hs_a += int'(hs_a);
                    c_vs_a += int'(vs_a);
                    c_de_a += int'(de_a);
                    c_fs   += int'(fs_a);
                    c_ls   += int'(ls_a);
                    c_hs_b += int'(!hs_b);
                    c_vs_b += int'(!vs_b);
                    c_de_b += int'(de_b);
                end
                // Hand totals over two whole frames from the first RUN cycle.
                if (x.chk_cnt) begin
                    chk("cnt_hsync_a", 32'(c_hs_a), 32'd48);
                    chk("cnt_vsync_a", 32'(c_vs_a), 32'd56);
                    chk("cnt_de_a",    32'(c_de_a), 32'd64);
                    chk("cnt_frame_start", 32'(c_fs), 32'd2);
                    chk("cnt_line_start",  32'(c_ls), 32'd16);
                    chk("cnt_hsync_b", 32'(c_hs_b), 32'd46);
                    chk("cnt_vsync_b", 32'(c_vs_b), 32'd56);
                    chk("cnt_de_b",    32'(c_de_b), 32'd64);
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) pb[i] = '0;
        // Reset, then idle with en low.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Start and run exactly two frames inside the counting window.
        repeat (F_LEN * 2 - 1) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        // Drop en mid-frame: frame completes, then idle and drain.
        run_to(3, 2);
        repeat (F_LEN - 31 + 6) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Reset mid-frame, then clean restart.
        run_to(5, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (130) step(1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_timing_gen.md
Name: screen_timing_gen

Overview:
- Raster timing master for the screen pipeline; sits directly upstream of the pixel-value stage.
- Generates horizontal/vertical counters and exposes them one stage early as prefetch coordinates pf_pix_row/pf_pix_col. The downstream stage registers its pixel value from these coordinates.
- Delays hsync, vsync and display-enable by PIX_LAT cycles so they align with that registered pixel value.
- Starts and stops only on whole-frame boundaries under control of en.

Parameters:
- H_ACTIVE, 834, visible columns
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 456, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active-high)
- V_POL, 1, vsync active level
- PIX_LAT, 1, downstream pixel latency in cycles; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run request
- hsync  out  1  horizontal sync, delayed PIX_LAT
- vsync  out  1  vertical sync, delayed PIX_LAT
- de  out  1  display enable, delayed PIX_LAT
- pf_pix_row  out  10  prefetch row (v counter)
- pf_pix_col  out  10  prefetch column (h counter)
- pf_active  out  1  prefetch coordinate is in the visible area and state is RUN
- frame_start  out  1  1-cycle pulse when prefetch coordinate is (0,0) in RUN
- line_start  out  1  1-cycle pulse when pf_pix_col==0 in RUN

Behaviour:
- Derived sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 994; V_TOTAL = 501.
- Elaboration error if H_TOTAL>1024, V_TOTAL>1024 or PIX_LAT<1.
- Reset (rst=1 at a clk edge):
  - state IDLE, counters 0, whole delay pipeline flushed to inactive levels.
  - Outputs: hsync=~H_POL, vsync=~V_POL, de=0, pf_pix_row=0, pf_pix_col=0, pf_active=0, frame_start=0, line_start=0.
  - Reset mid-frame takes effect on that same edge; there is no frame completion.
- States:
  - IDLE: counters held at 0. If en=1, go to RUN; the first RUN cycle presents (0,0) with frame_start=1.
  - RUN: h counter increments every cycle and wraps at H_TOTAL-1 → 0. On that wrap the v counter increments and wraps at V_TOTAL-1 → 0.
  - At the last cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1): if en=0, go to IDLE; else continue into (0,0).
  - en=0 mid-frame does not stop the frame; it completes.
  - en toggling within a frame is ignored; only its value at the last frame cycle matters.
- pf_pix_row and pf_pix_col are the raw registered counters. They run through blanking (col up to 993, row up to 500).
- Combinational decode on the current counters (all false in IDLE):
  - pf_active = (h<H_ACTIVE)&&(v<V_ACTIVE)&&RUN
  - hs_raw = h∈[H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_raw = v∈[V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines
  - frame_start, line_start as defined under Ports, undelayed.
- Delay: hs_raw, vs_raw and pf_active each pass through a PIX_LAT-deep register pipeline before output.
  - hsync = pipe(hs_raw) ? H_POL : ~H_POL; vsync likewise with V_POL.
  - de = pipe(pf_active).
  - The pipeline shifts every cycle, including in IDLE, so outputs drain to inactive levels PIX_LAT cycles after RUN ends.
- Exactly one vsync assertion per frame, so the downstream rising-edge detector sees one pulse per frame.

Decomposition:
- Shared package screen_pkg:
  - default timing constants (834/16/96/48, 456/10/2/33)
  - COORD_W=10
  - state enum {IDLE, RUN}
- One sub-module, screen_delay_line (params W, DEPTH): synchronous active-high reset to a parameterised RST_VAL; instantiated once with W=3 for {hs, vs, active}.

Test Plan:
All scenarios use small bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); frame = 112 cycles.
1. Reset then en=1 held → first RUN cycle has pf=(0,0) and frame_start=1; frame_start recurs every 112 cycles; line_start every 14 cycles.
2. Horizontal timing, PIX_LAT=1 → hsync high exactly 3 cycles per line, starting 1 cycle after pf_pix_col==10; de high 8 cycles per visible line, lagging pf_active by 1 cycle.
3. Vertical timing → vsync high for 28 consecutive cycles (rows 5–6), once per frame; de never high during rows 4–7.
4. en dropped at pf=(3,2) → counters continue to (13,7), then state IDLE with pf held (0,0); outputs inactive 1 cycle later; en re-raised → restart at (0,0).
5. rst pulsed at pf=(5,2) → next cycle pf=(0,0), pf_active=0, hsync=~H_POL, de=0; with en=1 the frame restarts cleanly.
6. H_POL=0, V_POL=0, PIX_LAT=3 → sync levels inverted (idle high); hsync/vsync/de lag the decode by exactly 3 cycles.
